// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_arbiter_dp.sv
// 2:1 payload mux plus valid/ready steering, driven by the registered select
// and a grant-active flag. Purely combinational.
module mux_arbiter_dp
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              sel_i,
  input  logic              gnt_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              ready_i,
  output logic              a_ready_o,
  output logic              b_ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic sel_a;

  assign sel_a     = (sel_i == SEL_A);
  assign data_o    = sel_a ? a_data_i : b_data_i;
  // The select always matches the granted side while a grant is active.
  assign valid_o   = gnt_i & (sel_a ? a_valid_i : b_valid_i);
  assign a_ready_o = gnt_i &  sel_a & ready_i;
  assign b_ready_o = gnt_i & ~sel_a & ready_i;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter with bounded hold, forwarding the granted
// valid/ready stream through a registered 2:1 mux select.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_sel,
  output logic              o_busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  arb_state_t    state_q, state_d;
  logic          sel_q, sel_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW:0]   cnt_inc;
  logic          hit;
  logic [CW-1:0] cnt_sat;
  logic          go_a, go_b, go_idle;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign hit     = (cnt_inc >= {1'b0, MAX_C});
  assign cnt_sat = hit ? MAX_C : cnt_inc[CW-1:0];

  always_comb begin
    go_a    = 1'b0;
    go_b    = 1'b0;
    go_idle = 1'b0;
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        go_a = i_a_valid & (~i_b_valid | (ptr_q == SEL_A));
        go_b = i_b_valid & (~i_a_valid | (ptr_q == SEL_B));
      end
      GNT_A: begin
        // Valid low means the burst is over, even under backpressure.
        if (!i_a_valid) begin
          go_b    = i_b_valid;
          go_idle = ~i_b_valid;
        end else if (i_ready) begin
          if (hit && i_b_valid) go_b  = 1'b1;
          else                  cnt_d = cnt_sat;
        end
      end
      GNT_B: begin
        if (!i_b_valid) begin
          go_a    = i_a_valid;
          go_idle = ~i_a_valid;
        end else if (i_ready) begin
          if (hit && i_a_valid) go_a  = 1'b1;
          else                  cnt_d = cnt_sat;
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Entry into a grant flips the pointer toward the other side.
    if (go_a) begin
      state_d = GNT_A;
      sel_d   = SEL_A;
      ptr_d   = SEL_B;
      cnt_d   = '0;
    end else if (go_b) begin
      state_d = GNT_B;
      sel_d   = SEL_B;
      ptr_d   = SEL_A;
      cnt_d   = '0;
    end else if (go_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_A;
      ptr_q   <= SEL_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sel  = sel_q;
  assign o_busy = (state_q != IDLE);

  mux_arbiter_dp #(.DATA_W(DATA_W)) u_dp (
    .sel_i     (sel_q),
    .gnt_i     (o_busy),
    .a_valid_i (i_a_valid),
    .a_data_i  (i_a_data),
    .b_valid_i (i_b_valid),
    .b_data_i  (i_b_data),
    .ready_i   (i_ready),
    .a_ready_o (o_a_ready),
    .b_ready_o (o_b_ready),
    .valid_o   (o_valid),
    .data_o    (o_data)
  );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, burst, contention, backpressure,
// async reset mid-burst, alternation and hold saturation.
module tb_mux_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk, rst_n;
  logic              a_valid, b_valid, rdy;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, o_valid, o_sel, o_busy;
  logic [DATA_W-1:0] o_data;

  int n_chk  = 0;
  int n_pass = 0;

  bit av [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
  bit bv [9] = '{1, 1, 0, 1, 1, 1, 0, 1, 1};
  bit es [9] = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
  bit ev [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

  mux_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_a_valid (a_valid),
    .i_a_data  (a_data),
    .o_a_ready (a_ready),
    .i_b_valid (b_valid),
    .i_b_data  (b_data),
    .o_b_ready (b_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (rdy),
    .o_sel     (o_sel),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // {o_valid, a_ready, b_ready, o_sel, o_busy} reset pattern
  task automatic chk_rst(input string tag);
    chk(tag, {27'd0, o_valid, a_ready, b_ready, o_sel, o_busy}, 32'b00010);
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; rdy = 1'b1;
    a_data = 8'h11; b_data = 8'h22;
    repeat (2) cyc();
    settle();
    chk_rst("reset");

    // single burst from A
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
    cyc();
    a_valid = 1'b1; a_data = 8'h11;
    settle();
    chk("burst_idle_valid", o_valid, 0);
    chk("burst_idle_busy", o_busy, 0);
    cyc(); settle();
    chk("burst_busy", o_busy, 1);
    chk("burst_a_ready", a_ready, 1);
    chk("burst_d0", o_data, 8'h11);
    cyc(); a_data = 8'h22; settle();
    chk("burst_d1", o_data, 8'h22);
    cyc(); a_data = 8'h33; settle();
    chk("burst_d2", o_data, 8'h33);
    chk("burst_valid", o_valid, 1);
    cyc(); a_valid = 1'b0; settle();
    chk("burst_end_valid", o_valid, 0);
    chk("burst_end_busy", o_busy, 1);
    cyc(); settle();
    chk("burst_idle_again", o_busy, 0);
    chk("burst_sel_hold", o_sel, 1);

    // contention: fresh reset so the pointer favours A
    rst_n = 1'b0; settle(); rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0;
    settle();
    cyc();
    for (int i = 0; i < MAX_HOLD; i++) begin
      settle();
      chk("cont_a_sel", o_sel, 1);
      chk("cont_a_data", o_data, 8'(8'hA0 + i));
      chk("cont_a_bready", b_ready, 0);
      cyc();
      a_data = 8'(8'hA1 + i);
    end
    settle();
    chk("cont_switch_sel", o_sel, 0);
    chk("cont_switch_bready", b_ready, 1);
    chk("cont_switch_aready", a_ready, 0);
    for (int j = 0; j < MAX_HOLD; j++) begin
      settle();
      chk("cont_b_data", o_data, 8'(8'hB0 + j));
      cyc();
      b_data = 8'(8'hB1 + j);
    end
    settle();
    chk("cont_back_sel", o_sel, 1);
    chk("cont_back_data", o_data, 8'hA4);
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    cyc(); settle();
    chk("cont_idle", o_busy, 0);

    // backpressure after two beats: counter must not advance while stalled
    a_valid = 1'b1; a_data = 8'h50;
    settle(); cyc(); settle();
    chk("bp_grant_a", o_sel, 1);
    cyc(); a_data = 8'h51;
    cyc(); a_data = 8'h52;
    rdy = 1'b0; b_valid = 1'b1; b_data = 8'h60;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_valid", o_valid, 1);
      chk("bp_data", o_data, 8'h52);
      chk("bp_sel", o_sel, 1);
      chk("bp_aready", a_ready, 0);
      cyc();
    end
    rdy = 1'b1; settle();
    chk("bp_release_aready", a_ready, 1);
    cyc(); a_data = 8'h53; settle();
    chk("bp_no_early_switch", o_sel, 1);
    chk("bp_data53", o_data, 8'h53);
    cyc(); a_data = 8'h54; settle();
    chk("bp_switch_sel", o_sel, 0);
    chk("bp_switch_data", o_data, 8'h60);

    // async reset during B's second beat
    cyc(); b_data = 8'h61; settle();
    chk("rst_mid_data", o_data, 8'h61);
    chk("rst_mid_bready", b_ready, 1);
    rst_n = 1'b0; settle();
    chk_rst("rst_mid_async");
    settle(); rst_n = 1'b1; settle();
    chk("rst_rel_idle", o_busy, 0);
    cyc(); settle();
    chk("rst_rel_sel_a", o_sel, 1);
    chk("rst_rel_data", o_data, 8'h54);
    chk("rst_rel_aready", a_ready, 1);
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    cyc(); settle();
    chk("rst_rel_idle2", o_busy, 0);

    // alternating single-beat bursts; pointer now favours B
    for (int c = 0; c < 9; c++) begin
      a_valid = av[c]; b_valid = bv[c];
      settle();
      if (c == 0) chk("alt_start_idle", o_busy, 0);
      else begin
        chk("alt_sel", o_sel, es[c]);
        chk("alt_valid", o_valid, ev[c]);
        chk("alt_busy", o_busy, 1);
      end
      cyc();
    end

    // B alone beyond MAX_HOLD keeps the grant
    a_valid = 1'b0; b_valid = 1'b1;
    for (int m = 0; m < MAX_HOLD + 2; m++) begin
      settle();
      chk("sat_hold_sel", o_sel, 0);
      chk("sat_hold_bready", b_ready, 1);
      cyc();
    end
    b_valid = 1'b0;
    cyc(); settle();
    chk("final_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
